// File: rtl/alu_pkg.sv
// Shared condition-code and flag definitions for the ALU writeback path.
// cond_pass() evaluates an ARM-style condition against a {V,Z,C,N} flag vector.
package alu_pkg;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  localparam int FLG_N = 0;
  localparam int FLG_C = 1;
  localparam int FLG_Z = 2;
  localparam int FLG_V = 3;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
    logic n, c, z, v;
    n = flags[FLG_N];
    c = flags[FLG_C];
    z = flags[FLG_Z];
    v = flags[FLG_V];
    case (cond)
      COND_EQ: return z;
      COND_NE: return !z;
      COND_CS: return c;
      COND_CC: return !c;
      COND_MI: return n;
      COND_PL: return !n;
      COND_VS: return v;
      COND_VC: return !v;
      COND_HI: return c & !z;
      COND_LS: return !c | z;
      COND_GE: return n == v;
      COND_LT: return n != v;
      COND_GT: return !z & (n == v);
      COND_LE: return z | (n != v);
      COND_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wb_sync_fifo.sv
// Small synchronous FIFO; a push is visible at the head one edge later.
// The head output holds the last popped entry while the FIFO is empty.
module wb_sync_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] head_dat_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  last_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      last_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        last_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

  assign head_dat_o = empty_o ? last_q : mem_q[rd_ptr_q];

endmodule

// File: rtl/alu_writeback_unit.sv
// Conditional-execution gate and flag register between the ALU and register-file write port.
// Passing writes reach the FIFO head one edge after accept; in_ready drops only on a full FIFO.
module alu_writeback_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic              alu_clk,
  input  logic              alu_rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_rslt,
  input  logic [3:0]        in_checks,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [3:0]        in_cond,
  input  logic              in_set_flags,
  input  logic              in_wr_en,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [3:0]        flags_q,
  output logic [CNT_W-1:0]  drop_cnt
);

  import alu_pkg::*;

  logic                     accept, pass, push, pop;
  logic                     fifo_full, fifo_empty;
  logic [3:0]               flags_d;
  logic [CNT_W-1:0]         drop_cnt_q, drop_cnt_d;
  logic [ADDR_W+DATA_W-1:0] head_dat;

  assign in_ready = alu_rst_n & ~fifo_full;
  assign accept   = in_valid & in_ready;
  assign pass     = cond_pass(in_cond, flags_q);
  assign push     = accept & pass & in_wr_en;
  assign pop      = wb_valid & wb_ready;

  always_comb begin
    flags_d    = flags_q;
    drop_cnt_d = drop_cnt_q;
    if (accept) begin
      if (pass) begin
        if (in_set_flags) flags_d = in_checks;
      end else if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge alu_clk) begin
    if (!alu_rst_n) begin
      flags_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      flags_q    <= flags_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  wb_sync_fifo #(
    .W     (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (alu_clk),
    .rst_n      (alu_rst_n),
    .push_i     (push),
    .push_dat_i ({in_rd, in_rslt}),
    .pop_i      (pop),
    .head_dat_o (head_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign wb_valid = ~fifo_empty;
  assign wb_addr  = head_dat[ADDR_W+DATA_W-1:DATA_W];
  assign wb_data  = head_dat[DATA_W-1:0];
  assign drop_cnt = drop_cnt_q;

endmodule
